// File: rtl/imem_fetch_if.sv
// Fetch-stage <-> instruction-memory responder bundle: request, response and program-load paths.
// The master side is the fetch stage / loader; the slave side is the memory responder.
interface imem_fetch_if #(
  parameter int unsigned XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic            flush;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [31:0]     rsp_instr;
  logic [XLEN-1:0] rsp_addr;
  logic            rsp_err;
  logic            wr_en;
  logic [XLEN-1:0] wr_addr;
  logic [31:0]     wr_data;

  modport master (
    output req_valid, req_addr, flush, rsp_ready, wr_en, wr_addr, wr_data,
    input  req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, flush, rsp_ready, wr_en, wr_addr, wr_data,
    output req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_err
  );
endinterface

// File: rtl/imem_fetch_responder.sv
// Instruction-fetch responder: fixed-latency pipelined RAM read feeding an in-order show-ahead
// response FIFO, with flush and a boot-time program-load write port.
module imem_fetch_responder #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input logic         clk,
  input logic         rst,
  imem_fetch_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned OW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [31:0] NopInstr = 32'h0000_0013;

  logic [31:0]     mem_q [DEPTH_WORDS];

  logic            ready_q;
  logic [OW-1:0]   out_q, out_d;
  logic [LATENCY-1:0] pv_q, pv_d, pe_q, pe_d;
  logic [XLEN-1:0] pa_q [LATENCY];
  logic [XLEN-1:0] pa_d [LATENCY];
  logic [31:0]     pdat_q [LATENCY];
  logic [31:0]     pdat_d [LATENCY];

  logic [31:0]     fi_q [FIFO_DEPTH];
  logic [31:0]     fi_d [FIFO_DEPTH];
  logic [XLEN-1:0] fa_q [FIFO_DEPTH];
  logic [XLEN-1:0] fa_d [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fe_q, fe_d;
  logic [PW-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [OW-1:0]   cnt_q, cnt_d;

  logic accept, rsp_hs, req_err, push;
  logic unused_wr_addr;

  // Word index ignores the byte-lane bits; upper address bits alias on writes.
  assign unused_wr_addr = ^{bus.wr_addr[XLEN-1:AW+2], bus.wr_addr[1:0]};

  assign bus.req_ready = ready_q & ~bus.flush & (out_q < OW'(FIFO_DEPTH));
  assign bus.rsp_valid = (cnt_q != '0);
  assign bus.rsp_instr = fi_q[rd_q];
  assign bus.rsp_addr  = fa_q[rd_q];
  assign bus.rsp_err   = fe_q[rd_q];

  assign accept  = bus.req_valid & bus.req_ready;
  assign rsp_hs  = bus.rsp_valid & bus.rsp_ready;
  assign req_err = (bus.req_addr[1:0] != 2'b00) | ((bus.req_addr >> 2) >= XLEN'(DEPTH_WORDS));
  assign push    = pv_q[LATENCY-1];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    pv_d      = '0;
    pe_d      = '0;
    pa_d      = pa_q;
    pdat_d    = pdat_q;
    pv_d[0]   = accept;
    pe_d[0]   = req_err;
    pa_d[0]   = bus.req_addr;
    pdat_d[0] = mem_q[bus.req_addr[AW+1:2]];
    for (int i = 1; i < LATENCY; i++) begin
      pv_d[i]   = pv_q[i-1];
      pe_d[i]   = pe_q[i-1];
      pa_d[i]   = pa_q[i-1];
      pdat_d[i] = pdat_q[i-1];
    end

    fi_d = fi_q;
    fa_d = fa_q;
    fe_d = fe_q;
    wr_d = wr_q;
    rd_d = rd_q;
    if (push) begin
      fi_d[wr_q] = pe_q[LATENCY-1] ? NopInstr : pdat_q[LATENCY-1];
      fa_d[wr_q] = pa_q[LATENCY-1];
      fe_d[wr_q] = pe_q[LATENCY-1];
      wr_d       = ptr_inc(wr_q);
    end
    if (rsp_hs) begin
      rd_d = ptr_inc(rd_q);
    end
    cnt_d = cnt_q + OW'(push) - OW'(rsp_hs);
    out_d = out_q + OW'(accept) - OW'(rsp_hs);

    // Flush drops everything in flight; a coincident handshake is already counted by the requester.
    if (bus.flush) begin
      pv_d  = '0;
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
      out_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q <= 1'b0;
      out_q   <= '0;
      pv_q    <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      fe_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fi_q[i] <= '0;
        fa_q[i] <= '0;
      end
    end else begin
      ready_q <= 1'b1;
      out_q   <= out_d;
      pv_q    <= pv_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      fe_q    <= fe_d;
      fi_q    <= fi_d;
      fa_q    <= fa_d;
    end
  end

  // RAM and datapath stages carry no reset; only the valids above qualify them.
  always_ff @(posedge clk) begin
    if (bus.wr_en) begin
      mem_q[bus.wr_addr[AW+1:2]] <= bus.wr_data;
    end
    pe_q   <= pe_d;
    pa_q   <= pa_d;
    pdat_q <= pdat_d;
  end
endmodule

// File: tb/tb_imem_fetch_responder.sv
// Self-checking bench for imem_fetch_responder: directed sequences, a vector table and random
// traffic, all checked against an in-order expected-response queue with ready-time stamps.
module tb_imem_fetch_responder;
  localparam int unsigned LAT = 2;
  localparam int unsigned FD  = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned cyc = 0;
  int          checks = 0;
  int          failures = 0;

  imem_fetch_if #(.XLEN(32)) bus ();

  imem_fetch_responder #(
    .XLEN(32), .DEPTH_WORDS(1024), .LATENCY(LAT), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic        err;
    int unsigned rdy;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic        err;
    int unsigned at;
  } hs_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic        err;
  } vec_t;

  exp_t        expq[$];
  hs_t         log_q[$];
  logic [31:0] mem_m [1024];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle, entered and left at posedge+1. acc reports the DUT's actual accept.
  task automatic cycle(input logic rv, input logic [31:0] ra, input logic rr, input logic fl,
                       input logic we, input logic [31:0] wa, input logic [31:0] wd,
                       output logic acc);
    logic ev, er, err;
    exp_t e;
    hs_t  h;
    ev = (expq.size() != 0) && (expq[0].rdy <= cyc);
    chkb("rsp_valid", bus.rsp_valid, ev);
    if (ev && bus.rsp_valid) begin
      chk("rsp_addr", bus.rsp_addr, expq[0].addr);
      chk("rsp_instr", bus.rsp_instr, expq[0].instr);
      chkb("rsp_err", bus.rsp_err, expq[0].err);
    end
    bus.req_valid = rv;
    bus.req_addr  = ra;
    bus.rsp_ready = rr;
    bus.flush     = fl;
    bus.wr_en     = we;
    bus.wr_addr   = wa;
    bus.wr_data   = wd;
    #1;
    er = !fl && (expq.size() < FD);
    chkb("req_ready", bus.req_ready, er);
    acc = rv && bus.req_ready;
    if (ev && rr) begin
      if (bus.rsp_valid) begin
        h.addr  = bus.rsp_addr;
        h.instr = bus.rsp_instr;
        h.err   = bus.rsp_err;
        h.at    = cyc;
        log_q.push_back(h);
      end
      void'(expq.pop_front());
    end
    if (rv && er) begin
      err     = (ra[1:0] != 2'b00) || ((ra >> 2) >= 32'd1024);
      e.addr  = ra;
      e.err   = err;
      e.instr = err ? NOP : mem_m[ra[11:2]];
      e.rdy   = cyc + 1 + LAT;
      expq.push_back(e);
    end
    if (fl) expq.delete();
    if (we) mem_m[wa[11:2]] = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rr);
    logic acc;
    cycle(1'b0, 32'h0, rr, 1'b0, 1'b0, 32'h0, 32'h0, acc);
  endtask

  task automatic drain(input int unsigned bound);
    for (int unsigned i = 0; i < bound && expq.size() != 0; i++) idle(1'b1);
    chk("drain_empty", expq.size(), 32'd0);
    idle(1'b1);
  endtask

  task automatic do_reset(input string tag);
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    bus.flush     = 1'b0;
    bus.wr_en     = 1'b0;
    rst = 1'b1;
    #1;
    chkb({tag, "_rst_req_ready"}, bus.req_ready, 1'b0);
    chkb({tag, "_rst_rsp_valid"}, bus.rsp_valid, 1'b0);
    chk({tag, "_rst_rsp_instr"}, bus.rsp_instr, 32'h0);
    chk({tag, "_rst_rsp_addr"}, bus.rsp_addr, 32'h0);
    chkb({tag, "_rst_rsp_err"}, bus.rsp_err, 1'b0);
    expq.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chkb({tag, "_rel_ready_low"}, bus.req_ready, 1'b0);
    @(posedge clk);
    #1;
    chkb({tag, "_rel_ready_high"}, bus.req_ready, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic        acc, rv, rr, fl, we;
    logic [31:0] ra, wa, wd;
    int unsigned n_acc, t0, w, r;
    vec_t        vecs[8];

    vecs[0] = '{32'h0000_0002, NOP,          1'b1};
    vecs[1] = '{32'h0000_1000, NOP,          1'b1};
    vecs[2] = '{32'h0000_0008, 32'h1000_0002, 1'b0};
    vecs[3] = '{32'h0000_0FFC, 32'hDEAD_BEEF, 1'b0};
    vecs[4] = '{32'h0000_0FFE, NOP,          1'b1};
    vecs[5] = '{32'h0000_0000, 32'h1000_0000, 1'b0};
    vecs[6] = '{32'h0000_007C, 32'h1000_001F, 1'b0};
    vecs[7] = '{32'hFFFF_FFFC, NOP,          1'b1};

    bus.req_valid = 1'b0;
    bus.req_addr  = 32'h0;
    bus.rsp_ready = 1'b0;
    bus.flush     = 1'b0;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = 32'h0;
    bus.wr_data   = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    do_reset("init");

    // Program load
    for (int i = 0; i < 32; i++) begin
      cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'(i * 4), 32'h1000_0000 + 32'(i), acc);
    end
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_0FFC, 32'hDEAD_BEEF, acc);

    // Streaming: 8 back-to-back fetches, rsp_ready held high
    log_q.delete();
    t0 = cyc;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 32'(i * 4), 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, acc);
    end
    drain(10);
    chk("stream_count", log_q.size(), 32'd8);
    if (log_q.size() == 8) begin
      chk("stream_first_at", log_q[0].at, t0 + 1 + LAT);
      chk("stream_last_at", log_q[7].at, t0 + 8 + LAT);
      for (int i = 0; i < 8; i++) begin
        chk("stream_instr", log_q[i].instr, 32'h1000_0000 + 32'(i));
        chk("stream_addr", log_q[i].addr, 32'(i * 4));
      end
    end

    // Backpressure: only FD requests may be outstanding
    log_q.delete();
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 32'h20 + 4 * n_acc, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, acc);
      if (acc) n_acc++;
    end
    chk("bp_accepted", n_acc, 32'd4);
    chkb("bp_ready_low", bus.req_ready, 1'b0);
    for (int i = 0; i < 30 && (n_acc < 6 || expq.size() != 0); i++) begin
      cycle(n_acc < 6, 32'h20 + 4 * n_acc, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, acc);
      if (acc) n_acc++;
    end
    chk("bp_total_acc", n_acc, 32'd6);
    chk("bp_rsp_count", log_q.size(), 32'd6);
    for (int i = 0; i < log_q.size(); i++) begin
      chk("bp_order", log_q[i].addr, 32'h20 + 32'(4 * i));
    end

    // Vector table: error and boundary addresses, one fetch each
    for (int v = 0; v < 8; v++) begin
      log_q.delete();
      cycle(1'b1, vecs[v].addr, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, acc);
      drain(10);
      chk("vec_count", log_q.size(), 32'd1);
      if (log_q.size() == 1) begin
        chk("vec_instr", log_q[0].instr, vecs[v].instr);
        chkb("vec_err", log_q[0].err, vecs[v].err);
        chk("vec_addr", log_q[0].addr, vecs[v].addr);
      end
    end

    // Flush with three in flight and a request presented during the flush
    log_q.delete();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 32'(i * 4), 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, acc);
    end
    cycle(1'b1, 32'h80, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, acc);
    chkb("flush_no_accept", acc, 1'b0);
    chkb("flush_rsp_valid_low", bus.rsp_valid, 1'b0);
    idle(1'b1);
    cycle(1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, acc);
    drain(10);
    chk("flush_count", log_q.size(), 32'd1);
    if (log_q.size() == 1) chk("flush_new_instr", log_q[0].instr, 32'h1000_0010);

    // Write/read collision on word 5
    log_q.delete();
    cycle(1'b1, 32'd20, 1'b1, 1'b0, 1'b1, 32'd20, 32'hCAFE_F00D, acc);
    cycle(1'b1, 32'd20, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, acc);
    drain(10);
    chk("coll_count", log_q.size(), 32'd2);
    if (log_q.size() == 2) begin
      chk("coll_old", log_q[0].instr, 32'h1000_0005);
      chk("coll_new", log_q[1].instr, 32'hCAFE_F00D);
    end

    // Reset in the middle of a stream
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 32'(i * 4), 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, acc);
    end
    do_reset("mid");
    for (int i = 0; i < 4; i++) idle(1'b1);

    // Random traffic against the reference queue
    for (int i = 0; i < 400; i++) begin
      w  = $urandom_range(0, 31);
      r  = $urandom_range(0, 9);
      rv = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 29) == 0);
      we = ($urandom_range(0, 9) == 0);
      if (r == 0)      ra = 32'(w * 4) + 32'($urandom_range(1, 3));
      else if (r == 1) ra = 32'h1000 + 32'(w * 4);
      else             ra = 32'(w * 4);
      wa = 32'($urandom_range(0, 31) * 4);
      wd = $urandom;
      cycle(rv, ra, rr, fl, we, wa, wd, acc);
    end
    drain(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
